// File: rtl/cache_data_array_if.sv
// rtl/cache_data_array_if.sv - read/write/refill bus bundle for the cache data array
interface cache_data_array_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 13,
   parameter int WAYS   = 2
);
   localparam int BYTES = DATA_W / 8;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic                    rd_en;
   logic [ADDR_W-1:0]       raddr;
   logic [WAYS*DATA_W-1:0]  rdata;

   logic                    we;
   logic                    wr_ready;
   logic [ADDR_W-1:0]       waddr;
   logic [WAY_W-1:0]        wway;
   logic [BYTES-1:0]        bsel;
   logic [DATA_W-1:0]       wdata;

   logic                    fill_start;
   logic [ADDR_W-1:0]       fill_addr;
   logic [WAY_W-1:0]        fill_way;
   logic                    fill_valid;
   logic [DATA_W-1:0]       fill_data;
   logic                    fill_ready;
   logic                    fill_busy;
   logic                    fill_done;

   modport master (
      output rd_en, raddr, we, waddr, wway, bsel, wdata,
             fill_start, fill_addr, fill_way, fill_valid, fill_data,
      input  rdata, wr_ready, fill_ready, fill_busy, fill_done
   );

   modport slave (
      input  rd_en, raddr, we, waddr, wway, bsel, wdata,
             fill_start, fill_addr, fill_way, fill_valid, fill_data,
      output rdata, wr_ready, fill_ready, fill_busy, fill_done
   );
endinterface

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - multi-way cache data RAM with critical-word-first refill sequencer (option: CACHE_BYPASS_EN)
module cache_data_array #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 13,
   parameter int WAYS       = 2,
   parameter int LINE_BEATS = 4
) (
   input logic                clk,
   input logic                rst,
   cache_data_array_if.slave  bus
);
   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int IDX_W  = ADDR_W - OFF_W;
   localparam int DEPTH  = 1 << IDX_W;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int BEAT_W = $clog2(LINE_BEATS);
   localparam int BASE_W = IDX_W - BEAT_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                 state_q, state_d;
   logic [BASE_W-1:0]      base_q, base_d;
   logic [WAY_W-1:0]       way_q, way_d;
   logic [BEAT_W-1:0]      ptr_q, ptr_d;
   logic [BEAT_W:0]        cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic [WAYS*DATA_W-1:0] rdata_q, rdata_d;

   logic [DATA_W-1:0]      mem [WAYS][DEPTH];

   logic                   busy;
   logic                   fill_wr;
   logic                   cpu_wr;
   logic                   wr_en;
   logic [WAY_W-1:0]       wr_way;
   logic [IDX_W-1:0]       wr_idx;
   logic [BYTES-1:0]       wr_be;
   logic [DATA_W-1:0]      wr_data;
   logic [IDX_W-1:0]       rd_idx;
   logic [DATA_W-1:0]      rd_word;

   // Byte-offset bits never address a word; collected here so they are visibly discarded.
   logic unused_offsets;
   assign unused_offsets = ^{bus.raddr[OFF_W-1:0], bus.waddr[OFF_W-1:0], bus.fill_addr[OFF_W-1:0]};

   assign busy         = (state_q == FILL);
   assign bus.fill_busy  = busy;
   assign bus.fill_ready = busy;
   assign bus.wr_ready   = ~busy;
   assign bus.fill_done  = done_q;
   assign bus.rdata      = rdata_q;
   assign rd_idx         = bus.raddr[ADDR_W-1:OFF_W];

   // Single write port: refill beats own it while filling, CPU writes only get it when idle.
   always_comb begin
      fill_wr = busy & bus.fill_valid & ~rst;
      cpu_wr  = bus.we & ~busy & ~rst;
      wr_en   = fill_wr | cpu_wr;
      if (fill_wr) begin
         wr_way  = way_q;
         wr_idx  = {base_q, ptr_q};
         wr_be   = '1;
         wr_data = bus.fill_data;
      end else begin
         wr_way  = bus.wway;
         wr_idx  = bus.waddr[ADDR_W-1:OFF_W];
         wr_be   = bus.bsel;
         wr_data = bus.wdata;
      end
   end

   // Refill sequencer: capture line/way/critical beat on start, then write beats wrapping in the line.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      way_d   = way_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.fill_start) begin
               state_d = FILL;
               base_d  = bus.fill_addr[ADDR_W-1 -: BASE_W];
               way_d   = bus.fill_way;
               ptr_d   = bus.fill_addr[OFF_W +: BEAT_W];
               cnt_d   = '0;
            end
         end
         FILL: begin
            if (bus.fill_valid) begin
               ptr_d = ptr_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == (BEAT_W+1)'(LINE_BEATS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Parallel read of every way; a same-cycle write either shows through or is hidden (read-first).
   always_comb begin
      rdata_d = rdata_q;
      rd_word = '0;
      if (bus.rd_en) begin
         for (int w = 0; w < WAYS; w++) begin
            rd_word = mem[w][rd_idx];
`ifdef CACHE_BYPASS_EN
            if (wr_en && (wr_way == WAY_W'(w)) && (wr_idx == rd_idx)) begin
               for (int b = 0; b < BYTES; b++) begin
                  if (wr_be[b]) rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
               end
            end
`endif
            rdata_d[w*DATA_W +: DATA_W] = rd_word;
         end
      end
   end

   // Control and read-data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         way_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         way_q   <= way_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM array with per-byte write enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b]) mem[wr_way][wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end
endmodule

// File: tb/tb_cache_data_array.sv
// tb/tb_cache_data_array.sv - directed self-checking bench for cache_data_array (honours CACHE_BYPASS_EN)
module tb_cache_data_array;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   cache_data_array_if #(.DATA_W(64), .ADDR_W(13), .WAYS(2)) bus ();

   cache_data_array #(.DATA_W(64), .ADDR_W(13), .WAYS(2), .LINE_BEATS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200us");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic way, input logic [12:0] addr, input logic [63:0] data, input logic [7:0] be);
      bus.we = 1'b1; bus.wway = way; bus.waddr = addr; bus.wdata = data; bus.bsel = be;
      tick();
      bus.we = 1'b0;
   endtask

   task automatic rd(input logic [12:0] addr);
      bus.rd_en = 1'b1; bus.raddr = addr;
      tick();
      bus.rd_en = 1'b0;
   endtask

   task automatic beat(input logic [63:0] data);
      bus.fill_valid = 1'b1; bus.fill_data = data;
      tick();
      bus.fill_valid = 1'b0;
   endtask

   task automatic start_fill(input logic [12:0] addr, input logic way);
      bus.fill_start = 1'b1; bus.fill_addr = addr; bus.fill_way = way;
      tick();
      bus.fill_start = 1'b0;
   endtask

   initial begin
      logic [127:0] expv;
      bus.rd_en = 1'b1; bus.raddr = '0;
      bus.we = 1'b0; bus.waddr = '0; bus.wway = '0; bus.bsel = '0; bus.wdata = '0;
      bus.fill_start = 1'b0; bus.fill_addr = '0; bus.fill_way = '0;
      bus.fill_valid = 1'b0; bus.fill_data = '0;

      // reset with a read pending
      tick();
      check("rst_rdata0", bus.rdata, 128'd0);
      check("rst_busy", 128'(bus.fill_busy), 128'd0);
      check("rst_ready", 128'(bus.fill_ready), 128'd0);
      check("rst_done", 128'(bus.fill_done), 128'd0);
      check("rst_wr_ready", 128'(bus.wr_ready), 128'd1);
      tick();
      check("rst_rdata1", bus.rdata, 128'd0);
      rst = 1'b0;
      bus.rd_en = 1'b0;

      // preload known words
      wr(1'b0, 13'h0000, 64'h0000_0000_AAAA_0000, 8'hFF);
      wr(1'b1, 13'h0000, 64'hBBBB_0000_0000_BBBB, 8'hFF);
      wr(1'b0, 13'h0008, 64'h0123_4567_89AB_CDEF, 8'hFF);
      wr(1'b0, 13'h0010, 64'h0, 8'hFF);
      wr(1'b0, 13'h0100, 64'h0000_0000_0000_5555, 8'hFF);

      rd(13'h0000);
      check("read_idx0", bus.rdata, {64'hBBBB_0000_0000_BBBB, 64'h0000_0000_AAAA_0000});
      tick();
      check("read_hold", bus.rdata, {64'hBBBB_0000_0000_BBBB, 64'h0000_0000_AAAA_0000});

      // byte-lane write; low offset bits of raddr ignored
      wr(1'b1, 13'h0008, 64'h1122_3344_5566_7788, 8'hFF);
      wr(1'b1, 13'h0008, 64'h0000_0000_0000_00AA, 8'h01);
      rd(13'h000F);
      check("byte_lane", bus.rdata, {64'h1122_3344_5566_77AA, 64'h0123_4567_89AB_CDEF});

      // read/write collision on way0 index 2
      bus.we = 1'b1; bus.wway = 1'b0; bus.waddr = 13'h0010; bus.wdata = 64'hFFFF; bus.bsel = 8'h03;
      bus.rd_en = 1'b1; bus.raddr = 13'h0010;
      tick();
      bus.we = 1'b0; bus.rd_en = 1'b0;
`ifdef CACHE_BYPASS_EN
      expv = 128'h0000_0000_0000_FFFF;
`else
      expv = 128'h0;
`endif
      check("collision", 128'(bus.rdata[63:0]), expv);
      rd(13'h0010);
      check("after_collision", 128'(bus.rdata[63:0]), 128'hFFFF);

      // critical-word-first refill of line 2, way0, starting at beat 2
      start_fill(13'h0050, 1'b0);
      check("fill1_busy", 128'(bus.fill_busy), 128'd1);
      check("fill1_ready", 128'(bus.fill_ready), 128'd1);
      check("fill1_wr_ready", 128'(bus.wr_ready), 128'd0);
      beat(64'hD0D0_0000_0000_0000);
      beat(64'hD1D1_0000_0000_0001);
      tick();
      check("fill1_gap_busy", 128'(bus.fill_busy), 128'd1);
      check("fill1_gap_done", 128'(bus.fill_done), 128'd0);
      beat(64'hD2D2_0000_0000_0002);
      check("fill1_wr_ready_mid", 128'(bus.wr_ready), 128'd0);
      beat(64'hD3D3_0000_0000_0003);
      check("fill1_done", 128'(bus.fill_done), 128'd1);
      check("fill1_idle", 128'(bus.fill_busy), 128'd0);
      // beat offered while idle must be dropped
      beat(64'hDEAD_DEAD_DEAD_DEAD);
      check("fill1_done_pulse", 128'(bus.fill_done), 128'd0);
      rd(13'h0050);
      check("fill1_w0A", 128'(bus.rdata[63:0]), 128'hD0D0_0000_0000_0000);
      rd(13'h0058);
      check("fill1_w0B", 128'(bus.rdata[63:0]), 128'hD1D1_0000_0000_0001);
      rd(13'h0040);
      check("fill1_w08", 128'(bus.rdata[63:0]), 128'hD2D2_0000_0000_0002);
      rd(13'h0048);
      check("fill1_w09", 128'(bus.rdata[63:0]), 128'hD3D3_0000_0000_0003);

      // CPU write held during a refill; restart attempt mid-fill ignored
      start_fill(13'h0200, 1'b1);
      bus.we = 1'b1; bus.wway = 1'b0; bus.waddr = 13'h0100; bus.wdata = 64'hC0DE_C0DE_C0DE_C0DE; bus.bsel = 8'hFF;
      beat(64'hE0E0_0000_0000_0000);
      check("fill2_wr_ready", 128'(bus.wr_ready), 128'd0);
      bus.fill_start = 1'b1; bus.fill_addr = 13'h0300; bus.fill_way = 1'b0;
      bus.rd_en = 1'b1; bus.raddr = 13'h0100;
      beat(64'hE1E1_0000_0000_0001);
      bus.fill_start = 1'b0; bus.rd_en = 1'b0;
      check("write_blocked", 128'(bus.rdata[63:0]), 128'h5555);
      beat(64'hE2E2_0000_0000_0002);
      beat(64'hE3E3_0000_0000_0003);
      check("fill2_done", 128'(bus.fill_done), 128'd1);
      check("fill2_wr_ready", 128'(bus.wr_ready), 128'd1);
      // held write lands now; new fill_start accepted alongside fill_done
      bus.fill_start = 1'b1; bus.fill_addr = 13'h0300; bus.fill_way = 1'b0;
      tick();
      bus.fill_start = 1'b0; bus.we = 1'b0;
      check("start_on_done", 128'(bus.fill_busy), 128'd1);
      rd(13'h0100);
      check("held_write", 128'(bus.rdata[63:0]), 128'hC0DE_C0DE_C0DE_C0DE);

      // reset after 2 of 4 beats
      beat(64'hF0F0_0000_0000_0000);
      beat(64'hF1F1_0000_0000_0001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 128'(bus.fill_busy), 128'd0);
      check("midrst_done", 128'(bus.fill_done), 128'd0);
      tick();
      check("midrst_done_after", 128'(bus.fill_done), 128'd0);
      start_fill(13'h0318, 1'b1);
      check("refill_busy", 128'(bus.fill_busy), 128'd1);
      beat(64'hA0A0_0000_0000_0000);
      beat(64'hA1A1_0000_0000_0001);
      beat(64'hA2A2_0000_0000_0002);
      check("refill_not_done", 128'(bus.fill_done), 128'd0);
      beat(64'hA3A3_0000_0000_0003);
      check("refill_done", 128'(bus.fill_done), 128'd1);

      rd(13'h0300);
      check("midrst_kept", 128'(bus.rdata[63:0]), 128'hF0F0_0000_0000_0000);
      check("refill_w60", 128'(bus.rdata[127:64]), 128'hA1A1_0000_0000_0001);
      rd(13'h0318);
      check("refill_w63", 128'(bus.rdata[127:64]), 128'hA0A0_0000_0000_0000);
      rd(13'h0200);
      check("fill2_w40", 128'(bus.rdata[127:64]), 128'hE0E0_0000_0000_0000);
      rd(13'h0218);
      check("fill2_w43", 128'(bus.rdata[127:64]), 128'hE3E3_0000_0000_0003);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
